// File: rtl/jt51_timer_ctrl_if.sv
// Host bus of the jt51 timer front end: YM2151-style write strobes,
// write data and the status/busy return path.
interface jt51_timer_ctrl_if;
  logic       cs_n;
  logic       wr_n;
  logic       a0;
  logic [7:0] din;
  logic [7:0] dout;
  logic       busy;

  // CPU side drives strobes and data, reads status
  modport master (
    output cs_n, wr_n, a0, din,
    input  dout, busy
  );

  // Register front end receives strobes and data, returns status
  modport slave (
    input  cs_n, wr_n, a0, din,
    output dout, busy
  );
endinterface

// File: rtl/jt51_timer_ctrl.sv
// jt51 timer register front end: decodes YM2151 writes to registers
// 0x10/0x11/0x12/0x14 into timer controls, runs the write-busy counter
// and returns the status byte {busy, 5'b0, flag_B, flag_A}.
module jt51_timer_ctrl #(
  parameter int BUSY_CYCLES = 32,
  parameter int BUSY_W      = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cen,
  jt51_timer_ctrl_if.slave     bus,
  input  logic                 flag_A,
  input  logic                 flag_B,
  output logic [9:0]           value_A,
  output logic [7:0]           value_B,
  output logic                 load_A,
  output logic                 load_B,
  output logic                 enable_irq_A,
  output logic                 enable_irq_B,
  output logic                 clr_flag_A,
  output logic                 clr_flag_B,
  output logic                 csm
);

  localparam logic [0:0]        ST_IDLE  = 1'b0;
  localparam logic [0:0]        ST_BUSY  = 1'b1;
  localparam logic [BUSY_W-1:0] LP_LOAD  = BUSY_W'(BUSY_CYCLES);
  localparam logic [BUSY_W-1:0] LP_ONE   = BUSY_W'(1);
  localparam bit                LP_BUSY_EN = (BUSY_CYCLES > 0);

  logic              r_strobe_prev;
  logic [7:0]        r_addr;
  logic [9:0]        r_value_A;
  logic [7:0]        r_value_B;
  logic              r_load_A;
  logic              r_load_B;
  logic              r_en_A;
  logic              r_en_B;
  logic              r_csm;
  logic              r_clr_A;
  logic              r_clr_B;
  logic [0:0]        r_state;
  logic [BUSY_W-1:0] r_cnt;
  logic [7:0]        r_dout;

  logic              w_strobe;
  logic              w_event;
  logic              w_addr_wr;
  logic              w_data_wr;
  logic              w_busy;

  assign w_busy    = (r_state == ST_BUSY);
  assign w_strobe  = ~bus.cs_n & ~bus.wr_n;
  assign w_event   = w_strobe & ~r_strobe_prev;
  assign w_addr_wr = w_event & ~bus.a0;
  // data writes arriving while busy are dropped without side effects
  assign w_data_wr = w_event & bus.a0 & ~w_busy;

  // Strobe history for edge detection, independent of cen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_strobe_prev <= 1'b0;
    else        r_strobe_prev <= w_strobe;
  end

  // Address latch, accepted even while busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_addr <= 8'h00;
    else if (w_addr_wr) r_addr <= bus.din;
  end

  // Register file decode; clear-flag strobes last exactly one clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value_A <= 10'h000;
      r_value_B <= 8'h00;
      r_load_A  <= 1'b0;
      r_load_B  <= 1'b0;
      r_en_A    <= 1'b0;
      r_en_B    <= 1'b0;
      r_csm     <= 1'b0;
      r_clr_A   <= 1'b0;
      r_clr_B   <= 1'b0;
    end else begin
      r_clr_A <= 1'b0;
      r_clr_B <= 1'b0;
      if (w_data_wr) begin
        case (r_addr)
          8'h10: r_value_A[9:2] <= bus.din;
          8'h11: r_value_A[1:0] <= bus.din[1:0];
          8'h12: r_value_B      <= bus.din;
          8'h14: begin
            r_csm    <= bus.din[7];
            r_clr_B  <= bus.din[5];
            r_clr_A  <= bus.din[4];
            r_en_B   <= bus.din[3];
            r_en_A   <= bus.din[2];
            r_load_B <= bus.din[1];
            r_load_A <= bus.din[0];
          end
          default: ;
        endcase
      end
    end
  end

  // Busy FSM: load on accepted data write, count down on cen, stop at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (w_data_wr && LP_BUSY_EN) begin
      r_state <= ST_BUSY;
      r_cnt   <= LP_LOAD;
    end else if (r_state == ST_BUSY && cen) begin
      if (r_cnt > LP_ONE) begin
        r_cnt <= r_cnt - LP_ONE;
      end else begin
        r_cnt   <= '0;
        r_state <= ST_IDLE;
      end
    end
  end

  // Status byte, registered every clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_dout <= 8'h00;
    else        r_dout <= {w_busy, 5'b00000, flag_B, flag_A};
  end

  assign bus.dout     = r_dout;
  assign bus.busy     = w_busy;
  assign value_A      = r_value_A;
  assign value_B      = r_value_B;
  assign load_A       = r_load_A;
  assign load_B       = r_load_B;
  assign enable_irq_A = r_en_A;
  assign enable_irq_B = r_en_B;
  assign clr_flag_A   = r_clr_A;
  assign clr_flag_B   = r_clr_B;
  assign csm          = r_csm;

endmodule

// File: tb/tb_jt51_timer_ctrl.sv
// Testbench for jt51_timer_ctrl: register-write vectors plus busy,
// strobe-hold, status, cen-freeze and asynchronous-reset sequences.
module tb_jt51_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cen;
  logic       flag_A, flag_B;
  logic [9:0] value_A;
  logic [7:0] value_B;
  logic       load_A, load_B, enable_irq_A, enable_irq_B;
  logic       clr_flag_A, clr_flag_B, csm;

  jt51_timer_ctrl_if bus();

  jt51_timer_ctrl #(.BUSY_CYCLES(32), .BUSY_W(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cen          (cen),
    .bus          (bus.slave),
    .flag_A       (flag_A),
    .flag_B       (flag_B),
    .value_A      (value_A),
    .value_B      (value_B),
    .load_A       (load_A),
    .load_B       (load_B),
    .enable_irq_A (enable_irq_A),
    .enable_irq_B (enable_irq_B),
    .clr_flag_A   (clr_flag_A),
    .clr_flag_B   (clr_flag_B),
    .csm          (csm)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_clrA  = 0;
  int n_clrB  = 0;
  int n_brise = 0;
  logic prev_busy = 1'b0;

  // pulse/edge monitor sampled 2 time units after each rising edge
  always @(posedge clk) begin
    #2;
    if (clr_flag_A) n_clrA++;
    if (clr_flag_B) n_clrB++;
    if (bus.busy && !prev_busy) n_brise++;
    prev_busy = bus.busy;
  end

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic [9:0] va;
    logic [7:0] vb;
    logic [4:0] ctl;   // {csm, enable_irq_B, enable_irq_A, load_B, load_A}
    int         clra;
    int         clrb;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int ctl_now();
    return int'({csm, enable_irq_B, enable_irq_A, load_B, load_A});
  endfunction

  // one-clk strobe; returns at the falling edge after the accepting edge
  task automatic bus_write(input logic a0v, input logic [7:0] d);
    @(negedge clk);
    bus.cs_n = 1'b0; bus.wr_n = 1'b0; bus.a0 = a0v; bus.din = d;
    @(negedge clk);
    bus.cs_n = 1'b1; bus.wr_n = 1'b1;
  endtask

  // counts rising edges until busy reads low, bounded
  task automatic wait_busy_low(output int n);
    n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) @(negedge clk);
  endtask

  int n;

  initial begin
    vecs[0] = '{8'h10, 8'hA5, 10'h294, 8'h00, 5'b00000, 0, 0};
    vecs[1] = '{8'h11, 8'hFE, 10'h296, 8'h00, 5'b00000, 0, 0};
    vecs[2] = '{8'h14, 8'h3F, 10'h296, 8'h00, 5'b01111, 1, 1};
    vecs[3] = '{8'h12, 8'h10, 10'h296, 8'h10, 5'b01111, 0, 0};
    vecs[4] = '{8'h14, 8'h84, 10'h296, 8'h10, 5'b10100, 0, 0};
    vecs[5] = '{8'h20, 8'hFF, 10'h296, 8'h10, 5'b10100, 0, 0};
    vecs[6] = '{8'h11, 8'h01, 10'h295, 8'h10, 5'b10100, 0, 0};

    rst_n = 1'b0; cen = 1'b1; flag_A = 1'b0; flag_B = 1'b0;
    bus.cs_n = 1'b1; bus.wr_n = 1'b1; bus.a0 = 1'b0; bus.din = 8'h00;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    chk("rst_busy",    int'(bus.busy), 0);
    chk("rst_dout",    int'(bus.dout), 0);
    chk("rst_value_A", int'(value_A),  0);
    chk("rst_value_B", int'(value_B),  0);
    chk("rst_ctl",     ctl_now(),      0);

    // register-write vectors
    for (int i = 0; i < 7; i++) begin
      bus_write(1'b0, vecs[i].addr);
      n_clrA = 0; n_clrB = 0;
      bus_write(1'b1, vecs[i].data);
      wait_busy_low(n);
      idle(1);
      chk($sformatf("v%0d_busy_cycles", i), n, 32);
      chk($sformatf("v%0d_value_A", i), int'(value_A), int'(vecs[i].va));
      chk($sformatf("v%0d_value_B", i), int'(value_B), int'(vecs[i].vb));
      chk($sformatf("v%0d_ctl", i),     ctl_now(),     int'(vecs[i].ctl));
      chk($sformatf("v%0d_clrA", i),    n_clrA,        vecs[i].clra);
      chk($sformatf("v%0d_clrB", i),    n_clrB,        vecs[i].clrb);
    end

    // data write dropped while busy; busy not extended
    bus_write(1'b0, 8'h12);
    bus_write(1'b1, 8'h10);
    chk("drop_busy_high", int'(bus.busy), 1);
    bus_write(1'b1, 8'h77);
    wait_busy_low(n);
    chk("drop_remaining", n, 30);
    chk("drop_value_B", int'(value_B), 'h10);
    bus_write(1'b1, 8'h77);
    chk("apply_value_B", int'(value_B), 'h77);

    // address write accepted while busy
    bus_write(1'b0, 8'h10);
    wait_busy_low(n);
    bus_write(1'b1, 8'h00);
    chk("addr_in_busy_value_A", int'(value_A), 'h001);
    wait_busy_low(n);

    // strobe held low for 100 clks: exactly one event
    bus_write(1'b0, 8'h14);
    n_clrA = 0; n_clrB = 0; n_brise = 0;
    @(negedge clk);
    bus.cs_n = 1'b0; bus.wr_n = 1'b0; bus.a0 = 1'b1; bus.din = 8'h10;
    idle(100);
    bus.cs_n = 1'b1; bus.wr_n = 1'b1;
    idle(3);
    chk("hold_clrA",      n_clrA,  1);
    chk("hold_clrB",      n_clrB,  0);
    chk("hold_busy_rise", n_brise, 1);
    chk("hold_busy_end",  int'(bus.busy), 0);
    chk("hold_ctl",       ctl_now(), 0);

    // status byte during and after busy
    bus_write(1'b1, 8'h00);
    flag_A = 1'b1; flag_B = 1'b0;
    @(negedge clk);
    chk("status_busy", int'(bus.dout), 'h81);
    wait_busy_low(n);
    chk("status_lag", int'(bus.dout), 'h81);
    @(negedge clk);
    chk("status_idle", int'(bus.dout), 'h01);
    flag_B = 1'b1;
    @(negedge clk);
    chk("status_flags", int'(bus.dout), 'h03);
    flag_A = 1'b0; flag_B = 1'b0;

    // cen low freezes the busy count
    bus_write(1'b1, 8'h00);
    idle(5);
    cen = 1'b0;
    idle(10);
    chk("cen_freeze_busy", int'(bus.busy), 1);
    cen = 1'b1;
    wait_busy_low(n);
    chk("cen_remaining", n, 27);

    // asynchronous reset in the middle of a busy period
    bus_write(1'b1, 8'h0F);
    flag_A = 1'b1;
    idle(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy",    int'(bus.busy), 0);
    chk("arst_dout",    int'(bus.dout), 0);
    chk("arst_value_A", int'(value_A),  0);
    chk("arst_value_B", int'(value_B),  0);
    chk("arst_ctl",     ctl_now(),      0);
    flag_A = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    chk("post_rst_busy", int'(bus.busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
